// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_BEQ  = 4'b0110;
  localparam logic [3:0] ALU_BNE  = 4'b0111;
  localparam logic [3:0] ALU_BGEZ = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_src_mux.sv
// ALU input ownership mux: the multiply sequencer wins while it owns the ALU,
// otherwise the EX-stage request passes straight through.
module alu_src_mux #(
  parameter int WIDTH = 32
) (
  input  logic             own,
  input  logic [3:0]       ex_alu_ctrl,
  input  logic [WIDTH-1:0] ex_entr1,
  input  logic [WIDTH-1:0] ex_entr2,
  input  logic [3:0]       seq_alu_ctrl,
  input  logic [WIDTH-1:0] seq_entr1,
  input  logic [WIDTH-1:0] seq_entr2,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] entr1,
  output logic [WIDTH-1:0] entr2
);

  assign alu_ctrl = own ? seq_alu_ctrl : ex_alu_ctrl;
  assign entr1    = own ? seq_entr1    : ex_entr1;
  assign entr2    = own ? seq_entr2    : ex_entr2;

endmodule

// File: rtl/alu_mult_seq.sv
// MULTU sequencer: 32 shift-add iterations through the shared ALU adder,
// stalling the pipeline while it owns the ALU inputs.
//
// state | meaning
// IDLE  | ALU passes EX request through; waits for start
// RUN   | one shift-add iteration per cycle, pipeline stalled
// DONE  | hi/lo freshly valid, done pulses, ALU back to pipeline
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       ex_alu_ctrl,
  input  logic [WIDTH-1:0] ex_entr1,
  input  logic [WIDTH-1:0] ex_entr2,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] entr1,
  output logic [WIDTH-1:0] entr2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   count_q;
  logic               own;
  logic               carry;
  logic               last_iter;
  logic [3:0]         seq_alu_ctrl;
  logic [WIDTH-1:0]   seq_entr1;
  logic [WIDTH-1:0]   seq_entr2;

  assign own          = (state == ST_RUN);
  assign seq_alu_ctrl = ALU_ADD;
  assign seq_entr1    = prod_q[2*WIDTH-1:WIDTH];
  assign seq_entr2    = prod_q[0] ? mcand_q : '0;

  // The ALU add is modulo WIDTH; a wrapped sum is smaller than either addend.
  assign carry     = (alu_result < seq_entr1);
  assign prod_next = {carry, alu_result, prod_q[WIDTH-1:1]};
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  assign busy  = (state != ST_IDLE);
  assign stall = own;
  assign done  = (state == ST_DONE);

  alu_src_mux #(
    .WIDTH(WIDTH)
  ) u_src_mux (
    .own          (own),
    .ex_alu_ctrl  (ex_alu_ctrl),
    .ex_entr1     (ex_entr1),
    .ex_entr2     (ex_entr2),
    .seq_alu_ctrl (seq_alu_ctrl),
    .seq_entr1    (seq_entr1),
    .seq_entr2    (seq_entr2),
    .alu_ctrl     (alu_ctrl),
    .entr1        (entr1),
    .entr2        (entr2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            prod_q  <= {{WIDTH{1'b0}}, op_b};
            mcand_q <= op_a;
            count_q <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          prod_q  <= prod_next;
          count_q <= count_q + CNT_W'(1);
          if (last_iter) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Results are captured from the final iteration so they are valid during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (own && last_iter) begin
      hi <= prod_next[2*WIDTH-1:WIDTH];
      lo <= prod_next[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: directed and random MULTU operands
// against a plain 64-bit product, plus timing, arbitration and reset checks.
module tb_alu_mult_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   ex_alu_ctrl = 4'b0000;
  logic [W-1:0] ex_entr1 = '0;
  logic [W-1:0] ex_entr2 = '0;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] entr1;
  logic [W-1:0] entr2;
  logic [W-1:0] alu_result;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  alu_mult_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .ex_alu_ctrl (ex_alu_ctrl),
    .ex_entr1    (ex_entr1),
    .ex_entr2    (ex_entr2),
    .alu_ctrl    (alu_ctrl),
    .entr1       (entr1),
    .entr2       (entr2),
    .alu_result  (alu_result),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  // Stand-in for the parent's ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = entr1 + entr2;
      4'b0001: alu_result = entr1 - entr2;
      4'b0010: alu_result = entr1 & entr2;
      4'b0011: alu_result = ~(entr1 | entr2);
      4'b0100: alu_result = entr1 | entr2;
      4'b0101: alu_result = {31'b0, ($signed(entr1) < $signed(entr2))};
      default: alu_result = entr1 - entr2;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ex();
    ex_alu_ctrl = 4'($urandom_range(0, 5));
    ex_entr1    = $urandom;
    ex_entr2    = $urandom;
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [63:0]  prod;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    int done_cyc, done_cnt, stall_cnt, busy_fall, own_err, hold_err, pass_err;
    prod = {32'b0, a} * {32'b0, b};
    done_cyc = -1; done_cnt = 0; stall_cnt = 0; busy_fall = -1;
    own_err = 0; hold_err = 0; pass_err = 0;
    got_hi = '0; got_lo = '0;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; rand_ex();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      rand_ex();
      if (inject && (cyc == 5 || cyc == 33)) begin
        start = 1'b1;
        op_a  = $urandom;
        op_b  = $urandom;
      end
      #1;
      if (stall) begin
        stall_cnt++;
        if (alu_ctrl !== 4'b0000) own_err++;
      end else if (alu_ctrl !== ex_alu_ctrl || entr1 !== ex_entr1 || entr2 !== ex_entr2) begin
        pass_err++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        got_hi = hi;
        got_lo = lo;
      end else if (done_cyc < 0 && (hi !== model_hi || lo !== model_lo)) begin
        hold_err++;
      end
      if (busy_fall < 0 && !busy) busy_fall = cyc;
    end
    check("done_cycle", 64'(done_cyc), 64'd33);
    check("done_count", 64'(done_cnt), 64'd1);
    check("stall_cycles", 64'(stall_cnt), 64'd32);
    check("busy_fall_cycle", 64'(busy_fall), 64'd34);
    check("alu_owned_in_run", 64'(own_err), 64'd0);
    check("pass_through_idle", 64'(pass_err), 64'd0);
    check("hilo_hold_in_run", 64'(hold_err), 64'd0);
    check("hi_at_done", 64'(got_hi), 64'(prod[63:32]));
    check("lo_at_done", 64'(got_lo), 64'(prod[31:0]));
    check("hilo_held_after", {hi, lo}, prod);
    model_hi = prod[63:32];
    model_lo = prod[31:0];
  endtask

  initial begin
    int dn;
    ex_alu_ctrl = 4'b0100; ex_entr1 = 32'hA5A5_0000; ex_entr2 = 32'h0000_5A5A;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_pass_ctrl", 64'(alu_ctrl), 64'h4);
    check("rst_pass_entr1", 64'(entr1), 64'hA5A5_0000);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    ex_alu_ctrl = 4'b0001; ex_entr1 = 32'd9; ex_entr2 = 32'd4;
    #1;
    check("idle_ctrl", 64'(alu_ctrl), 64'h1);
    check("idle_entr1", 64'(entr1), 64'd9);
    check("idle_entr2", 64'(entr2), 64'd4);
    check("idle_result", 64'(alu_result), 64'd5);

    run_mult(32'd3, 32'd5, 1'b0);
    check("3x5_lo", 64'(lo), 64'd15);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("max_lo", 64'(lo), 64'h0000_0001);
    run_mult(32'h1234_5678, 32'd0, 1'b0);
    run_mult(32'h8000_0000, 32'd2, 1'b0);
    check("msb_x2_hi", 64'(hi), 64'd1);
    run_mult(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_mult($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    run_mult(32'hFFFF_FFFF, 32'd3, 1'b0);

    // Reset asserted mid-RUN, at cycle 10 of a fresh multiply.
    @(negedge clk);
    op_a = $urandom; op_b = $urandom; start = 1'b1;
    for (int cyc = 1; cyc < 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    ex_alu_ctrl = 4'b0010; ex_entr1 = 32'hF0F0_1234; ex_entr2 = 32'h0FF0_FFFF;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_pass", {28'b0, alu_ctrl, entr1}, {28'b0, 4'b0010, 32'hF0F0_1234});
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    repeat (36) begin
      @(negedge clk);
      #1;
      if (done || busy) dn++;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    run_mult(32'd7, 32'd6, 1'b0);
    check("after_rst_lo", 64'(lo), 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle unsigned multiply sequencer and ALU-sharing arbiter for the EX stage of the pipelined datapath. It implements MULTU (32×32→64) by 32 shift-add iterations that reuse the existing 32-bit ALU's ADD operation, so no dedicated multiplier is needed. While a multiply runs, it takes ownership of the ALU inputs from the pipeline and stalls the pipeline. Otherwise it passes the EX-stage ALU request through unchanged.

## Interface
Parameters:
- WIDTH, 32, operand and ALU data width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin MULTU; sampled only in IDLE.
- op_a  in  WIDTH  multiplicand (rs).
- op_b  in  WIDTH  multiplier (rt).
- ex_alu_ctrl  in  4  pipeline EX-stage ALU opcode.
- ex_entr1, ex_entr2  in  WIDTH  pipeline EX-stage ALU operands.
- alu_ctrl  out  4  opcode to ALU.
- entr1, entr2  out  WIDTH  operands to ALU.
- alu_result  in  WIDTH  ALU result, combinational from alu_ctrl/entr1/entr2.
- busy  out  1  state != IDLE.
- stall  out  1  pipeline hold request; equals state == RUN.
- done  out  1  one-cycle pulse; hi/lo are newly valid.
- hi, lo  out  WIDTH  product upper and lower halves; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN when start=1.
  - RUN→DONE when the iteration count reaches WIDTH.
  - DONE→IDLE unconditionally.
- Start accept (IDLE, start=1):
  - P = {WIDTH'b0, op_b} (2·WIDTH product register).
  - M = op_a.
  - count = 0.
- Per RUN cycle:
  - Drive alu_ctrl=4'b0000 (ADD), entr1=P[2W-1:W], entr2 = P[0] ? M : 0.
  - Carry c = (alu_result < entr1), an unsigned compare done locally.
  - On the edge, P ← {c, alu_result, P[W-1:1]}, count ← count+1.
- DONE:
  - hi ← P[2W-1:W], lo ← P[W-1:0], both registered.
  - done=1 for this cycle only.
- Arbitration:
  - In IDLE and DONE, alu_ctrl/entr1/entr2 = ex_* (pure combinational pass-through).
  - In RUN, the sequencer owns the ALU and ex_* are ignored.
- start in RUN or DONE is ignored: no queueing, and the result in progress is unaffected.
- Only unsigned multiply is supported; the decoder must not issue signed MULT to this block.
- All arithmetic is modulo WIDTH except the carry bit, which is explicitly recovered as above.

## Timing
- Reset (async assert, sync-safe deassert at next edge) forces:
  - state=IDLE.
  - P, M, count = 0.
  - hi = lo = 0.
  - busy = stall = done = 0.
  - ALU outputs equal the ex_* pass-through.
- Reset mid-RUN aborts the operation: hi/lo clear to 0 and no done pulse is produced.
- Latency: start sampled at edge 0; RUN occupies cycles 1..WIDTH (iterations update at edges 1..WIDTH); DONE is cycle WIDTH+1 (33 for WIDTH=32); IDLE again at cycle WIDTH+2.
- A back-to-back start is earliest at cycle WIDTH+2. Throughput is one multiply per WIDTH+2 cycles.
- stall is high for exactly WIDTH cycles per multiply. busy is high for WIDTH+1 cycles.
- hi/lo change only at the DONE-entry edge and on reset.

## Structure
- Shared package alu_pkg:
  - ALU opcode constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_NOR=4'b0011, ALU_OR=4'b0100, ALU_SLT=4'b0101, ALU_BEQ=4'b0110, ALU_BNE=4'b0111, ALU_BGEZ=4'b1111.
  - Sequencer state enum {IDLE, RUN, DONE}.
- Sub-module alu_src_mux: the 3-signal ownership mux, selected by the own=RUN signal.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- op_a=3, op_b=5, start at cycle 0 → done=1 only in cycle 33; hi=0, lo=15; stall high in cycles 1–32.
- op_a=op_b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001 (carry path exercised every iteration).
- IDLE with ex_alu_ctrl=4'b0001, ex_entr1=9, ex_entr2=4 → alu_ctrl=0001, entr1=9, entr2=4, alu_result=5. During RUN, alu_ctrl=0000 regardless of ex_*.
- op_a=32'h12345678, op_b=0 → hi=lo=0. Then op_a=32'h80000000, op_b=2 → hi=1, lo=0.
- start re-asserted in cycles 5 and 33 with different operands → ignored; result matches the first operands; busy falls at cycle 34.
- rst_n low at cycle 10 mid-RUN → immediately IDLE, busy=stall=0, hi=lo=0, no done pulse. A new start with 7×6 after release → lo=42 at DONE.
